// File: rtl/rx_iq_readout_if.sv
// rx_iq_readout_if: sample inputs, CPU readout and overflow signals of the I/Q readout block
interface rx_iq_readout_if #(
  parameter int NCH = 4,
  parameter int W   = 24
);
  logic [NCH-1:0]   in_avail;
  logic [NCH*W-1:0] in_i;
  logic [NCH*W-1:0] in_q;
  logic [1:0]       mode;
  logic             rd_ack;
  logic [15:0]      dout;
  logic             dout_valid;
  logic [2:0]       dout_chan;
  logic             dout_last;
  logic [NCH-1:0]   ovfl;
  logic             ovfl_clr;
  modport master (
    output in_avail, in_i, in_q, mode, rd_ack, ovfl_clr,
    input  dout, dout_valid, dout_chan, dout_last, ovfl
  );
  modport slave (
    input  in_avail, in_i, in_q, mode, rd_ack, ovfl_clr,
    output dout, dout_valid, dout_chan, dout_last, ovfl
  );
endinterface

// File: rtl/rx_iq_readout.sv
// rx_iq_readout: per-channel I/Q FIFOs, round-robin serialized into 16-bit CPU words
module rx_iq_readout #(
  parameter int NCH   = 4,
  parameter int W     = 24,
  parameter int DEPTH = 8
) (
  input logic          adc_clk,
  input logic          reset,
  rx_iq_readout_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, WORD} state_t;
  state_t state_q, state_d;
  logic [2*W-1:0] mem [NCH][DEPTH];
  logic [NCH-1:0][AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [NCH-1:0] empty, full, push, pop, ovfl_q, ovfl_d;
  logic [CW-1:0] sel, idx, rr_q, rr_d, chan_q, chan_d;
  logic hit, pop_any, ack;
  logic [2*W-1:0] samp_q, samp_d;
  logic [1:0] mode_q, mode_d, widx_q, widx_d, lidx;
  logic [15:0] dout_q, dout_d, w0, w1, w2;
  logic valid_q, valid_d, last_q, last_d;
  logic [23:0] i24, q24;
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      empty[c] = wp_q[c] == rp_q[c];
      full[c]  = (wp_q[c][AW] != rp_q[c][AW]) && (wp_q[c][AW-1:0] == rp_q[c][AW-1:0]);
    end
  end
  // first non-empty channel after the last one served
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = CW'((int'(rr_q) + k) % NCH);
      if (!empty[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
  end
  always_comb begin
    pop_any = state_q == IDLE && hit;
    for (int c = 0; c < NCH; c++) begin
      pop[c]  = pop_any && sel == CW'(c);
      push[c] = bus.in_avail[c] && (!full[c] || pop[c]);
      wp_d[c] = wp_q[c] + (AW+1)'(push[c]);
      rp_d[c] = rp_q[c] + (AW+1)'(pop[c]);
    end
    ovfl_d = (ovfl_q & ~{NCH{bus.ovfl_clr}}) | (bus.in_avail & full & ~pop);
  end
  always_ff @(posedge adc_clk) begin
    for (int c = 0; c < NCH; c++)
      if (push[c]) mem[c][wp_q[c][AW-1:0]] <= {bus.in_i[c*W +: W], bus.in_q[c*W +: W]};
  end
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      ovfl_q  <= '0;
      rr_q    <= CW'(NCH - 1);
      chan_q  <= '0;
      samp_q  <= '0;
      mode_q  <= '0;
      widx_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      ovfl_q  <= ovfl_d;
      rr_q    <= rr_d;
      chan_q  <= chan_d;
      samp_q  <= samp_d;
      mode_q  <= mode_d;
      widx_q  <= widx_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end
  always_comb begin
    lidx    = mode_q == 2'd1 ? 2'd2 : mode_q == 2'd2 ? 2'd0 : 2'd1;
    state_d = state_q == IDLE ? (hit ? LOAD : IDLE) :
              state_q == LOAD ? WORD :
              (bus.rd_ack && widx_q == lidx) ? IDLE : WORD;
  end
  // samples left-justified to 24 bits; 16- and 8-bit views are the top bits
  always_comb begin
    i24     = 24'((32'(samp_q[2*W-1:W]) << (32 - W)) >> 8);
    q24     = 24'((32'(samp_q[W-1:0]) << (32 - W)) >> 8);
    w0      = mode_q == 2'd2 ? {i24[23:16], q24[23:16]} : i24[23:8];
    w1      = mode_q == 2'd1 ? {i24[7:0], q24[23:16]} : q24[23:8];
    w2      = q24[15:0];
    ack     = state_q == WORD && bus.rd_ack;
    samp_d  = pop_any ? mem[sel][rp_q[sel][AW-1:0]] : samp_q;
    mode_d  = pop_any ? bus.mode : mode_q;
    rr_d    = pop_any ? sel : rr_q;
    chan_d  = state_q == LOAD ? rr_q : chan_q;
    widx_d  = state_q == LOAD ? 2'd0 : ack ? widx_q + 2'd1 : widx_q;
    dout_d  = state_q == LOAD ? w0 : (ack && widx_q != lidx) ? (widx_q == 2'd0 ? w1 : w2) : dout_q;
    last_d  = state_q == LOAD ? lidx == 2'd0 : ack ? widx_q + 2'd1 == lidx : last_q;
    valid_d = state_q == LOAD ? 1'b1 : (ack && widx_q == lidx) ? 1'b0 : valid_q;
  end
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.dout_chan  = 3'(chan_q);
  assign bus.dout_last  = last_q;
  assign bus.ovfl       = ovfl_q;
endmodule

// File: tb/tb_rx_iq_readout.sv
// tb_rx_iq_readout: directed vectors with hand-computed words for rx_iq_readout
module tb_rx_iq_readout;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  rx_iq_readout_if #(.NCH(4), .W(24)) bus();
  rx_iq_readout #(.NCH(4), .W(24), .DEPTH(8)) dut (
    .adc_clk(clk),
    .reset(rst),
    .bus(bus.slave)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask
  task automatic push(logic [3:0] m, logic [23:0] i, logic [23:0] q);
    bus.in_i     = {4{i}};
    bus.in_q     = {4{q}};
    bus.in_avail = m;
    tick;
    bus.in_avail = '0;
  endtask
  task automatic rd(string tag, logic [15:0] w, logic l, logic [2:0] ch);
    int n = 0;
    while (!bus.dout_valid && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.dout_valid), 1);
    chk({tag, "_dout"}, 32'(bus.dout), 32'(w));
    chk({tag, "_last"}, 32'(bus.dout_last), 32'(l));
    chk({tag, "_chan"}, 32'(bus.dout_chan), 32'(ch));
    bus.rd_ack = 1'b1;
    tick;
    bus.rd_ack = 1'b0;
  endtask
  int exp_k [9] = '{2, 3, 4, 5, 6, 7, 8, 9, 12};
  initial begin
    bus.in_avail = '0;
    bus.in_i     = '0;
    bus.in_q     = '0;
    bus.mode     = 2'd0;
    bus.rd_ack   = 1'b0;
    bus.ovfl_clr = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    tick;
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_valid", 32'(bus.dout_valid), 0);
    chk("rst_chan", 32'(bus.dout_chan), 0);
    chk("rst_last", 32'(bus.dout_last), 0);
    chk("rst_ovfl", 32'(bus.ovfl), 0);
    push(4'b0010, 24'h123456, 24'hABCDEF);
    chk("lat_t1", 32'(bus.dout_valid), 0);
    tick;
    chk("lat_t2", 32'(bus.dout_valid), 0);
    tick;
    chk("lat_t3", 32'(bus.dout_valid), 1);
    rd("m0_w0", 16'h1234, 1'b0, 3'd1);
    rd("m0_w1", 16'hABCD, 1'b1, 3'd1);
    chk("m0_done", 32'(bus.dout_valid), 0);
    bus.mode = 2'd1;
    push(4'b0010, 24'h123456, 24'hABCDEF);
    rd("m1_w0", 16'h1234, 1'b0, 3'd1);
    rd("m1_w1", 16'h56AB, 1'b0, 3'd1);
    rd("m1_w2", 16'hCDEF, 1'b1, 3'd1);
    bus.mode = 2'd2;
    push(4'b0010, 24'h123456, 24'hABCDEF);
    rd("m2_w0", 16'h12AB, 1'b1, 3'd1);
    chk("m2_done", 32'(bus.dout_valid), 0);
    do_reset;
    bus.mode     = 2'd0;
    bus.in_i     = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
    bus.in_q     = {24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA};
    bus.in_avail = 4'hF;
    tick;
    bus.in_avail = '0;
    for (int c = 0; c < 3; c++) begin
      rd("rr_i", 16'(16'h1111 * (c + 1)), 1'b0, 3'(c));
      rd("rr_q", 16'(16'hAAAA + 16'h1111 * c), 1'b1, 3'(c));
    end
    bus.in_i     = {24'h666666, 24'h0, 24'h0, 24'h555555};
    bus.in_q     = {24'h999999, 24'h0, 24'h0, 24'h888888};
    bus.in_avail = 4'b1001;
    tick;
    bus.in_avail = '0;
    rd("rr3a_i", 16'h4444, 1'b0, 3'd3);
    rd("rr3a_q", 16'hDDDD, 1'b1, 3'd3);
    rd("rr0_i", 16'h5555, 1'b0, 3'd0);
    rd("rr0_q", 16'h8888, 1'b1, 3'd0);
    rd("rr3b_i", 16'h6666, 1'b0, 3'd3);
    rd("rr3b_q", 16'h9999, 1'b1, 3'd3);
    // sample 1 sits in the output stage, so 9 pushes leave FIFO 0 exactly full
    do_reset;
    for (int k = 1; k <= 9; k++) push(4'b0001, {16'(k), 8'h0}, {16'(k + 256), 8'h0});
    chk("ovfl_full", 32'(bus.ovfl), 0);
    push(4'b0001, {16'd10, 8'h0}, {16'd266, 8'h0});
    chk("ovfl_set", 32'(bus.ovfl), 1);
    bus.ovfl_clr = 1'b1;
    push(4'b0001, {16'd11, 8'h0}, {16'd267, 8'h0});
    bus.ovfl_clr = 1'b0;
    chk("ovfl_setwins", 32'(bus.ovfl), 1);
    bus.ovfl_clr = 1'b1;
    tick;
    bus.ovfl_clr = 1'b0;
    chk("ovfl_clr", 32'(bus.ovfl), 0);
    rd("ov1_i", 16'd1, 1'b0, 3'd0);
    rd("ov1_q", 16'd257, 1'b1, 3'd0);
    push(4'b0001, {16'd12, 8'h0}, {16'd268, 8'h0});
    chk("ovfl_poppush", 32'(bus.ovfl), 0);
    for (int n = 0; n < 9; n++) begin
      rd("ovd_i", 16'(exp_k[n]), 1'b0, 3'd0);
      rd("ovd_q", 16'(exp_k[n] + 256), 1'b1, 3'd0);
    end
    chk("ovd_empty", 32'(bus.dout_valid), 0);
    do_reset;
    bus.mode = 2'd0;
    push(4'b0100, 24'h123456, 24'hABCDEF);
    push(4'b0100, 24'h654321, 24'hFEDCBA);
    rd("ms_w0", 16'h1234, 1'b0, 3'd2);
    bus.mode = 2'd2;
    rd("ms_w1", 16'hABCD, 1'b1, 3'd2);
    rd("ms_next", 16'h65FE, 1'b1, 3'd2);
    chk("ms_done", 32'(bus.dout_valid), 0);
    bus.mode = 2'd1;
    push(4'b0010, 24'h123456, 24'hABCDEF);
    push(4'b0010, 24'h123456, 24'hABCDEF);
    rd("mr_w0", 16'h1234, 1'b0, 3'd1);
    chk("mr_w1", 32'(bus.dout), 32'h56AB);
    rst = 1'b1;
    #1;
    chk("mr_dout", 32'(bus.dout), 0);
    chk("mr_valid", 32'(bus.dout_valid), 0);
    chk("mr_chan", 32'(bus.dout_chan), 0);
    chk("mr_last", 32'(bus.dout_last), 0);
    tick;
    rst = 1'b0;
    repeat (10) tick;
    chk("mr_stale", 32'(bus.dout_valid), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
